// File: rtl/acc_cpu_p.sv
// Accumulator CPU: two-cycle FETCH/EXEC machine with private
// instruction and data memories loadable while idle.
module acc_cpu_p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    localparam int IW = 4 + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic [IW-1:0]     imem_wdata,
    input  logic              dmem_we,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              zf,
    output logic              cf,
    output logic              busy,
    output logic              halt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_AND = 4'h9;
    localparam logic [3:0] OP_OR  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int DEPTH = 2 ** ADDR_W;

    state_t            state;
    logic [IW-1:0]     ir;
    logic [IW-1:0]     imem [DEPTH];
    logic [DATA_W-1:0] dmem [DEPTH];

    logic [3:0]        op;
    logic [ADDR_W-1:0] m;
    logic [DATA_W-1:0] mem_d;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [ADDR_W-1:0] pc_inc;

    logic [DATA_W-1:0] acc_n;
    logic [ADDR_W-1:0] pc_n;
    logic              zf_n;
    logic              cf_n;
    logic              upd_z;
    logic              hlt_n;
    logic              sta_we;

    assign op     = ir[3:0];
    assign m      = ir[IW-1:4];
    assign mem_d  = dmem[m];
    assign sum    = {1'b0, acc} + {1'b0, mem_d};
    assign diff   = {1'b0, acc} - {1'b0, mem_d};
    assign pc_inc = pc + ADDR_W'(1);
    assign sta_we = (state == S_EXEC) && (op == OP_STA);

    // Decode the held instruction into next acc/flags/pc values.
    always_comb begin
        acc_n = acc;
        pc_n  = pc_inc;
        zf_n  = zf;
        cf_n  = cf;
        upd_z = 1'b0;
        hlt_n = 1'b0;
        case (op)
            OP_LDA: begin
                acc_n = mem_d;
                upd_z = 1'b1;
            end
            OP_ADD: begin
                acc_n = sum[DATA_W-1:0];
                cf_n  = sum[DATA_W];
                upd_z = 1'b1;
            end
            OP_SUB: begin
                acc_n = diff[DATA_W-1:0];
                cf_n  = diff[DATA_W];
                upd_z = 1'b1;
            end
            OP_LDI: begin
                acc_n = DATA_W'(m);
                upd_z = 1'b1;
            end
            OP_JMP: pc_n = m;
            OP_JZ: begin
                if (zf) pc_n = m;
            end
            OP_JC: begin
                if (cf) pc_n = m;
            end
            OP_AND: begin
                acc_n = acc & mem_d;
                upd_z = 1'b1;
            end
            OP_OR: begin
                acc_n = acc | mem_d;
                upd_z = 1'b1;
            end
            OP_HLT: begin
                pc_n  = pc;
                hlt_n = 1'b1;
            end
            default: ;
        endcase
        if (upd_z) zf_n = (acc_n == '0);
    end

    // Control FSM with registered architectural state and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
            acc   <= '0;
            zf    <= 1'b0;
            cf    <= 1'b0;
            ir    <= '0;
            busy  <= 1'b0;
            halt  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state <= S_FETCH;
                        pc    <= '0;
                        acc   <= '0;
                        zf    <= 1'b0;
                        cf    <= 1'b0;
                        busy  <= 1'b1;
                        halt  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir    <= imem[pc];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    pc  <= pc_n;
                    acc <= acc_n;
                    zf  <= zf_n;
                    cf  <= cf_n;
                    if (hlt_n) begin
                        state <= S_HALTED;
                        busy  <= 1'b0;
                        halt  <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memories: load port while idle, STA store during EXEC; never cleared.
    always_ff @(posedge clk) begin
        if (imem_we && !busy) imem[imem_addr] <= imem_wdata;
        if (dmem_we && !busy) dmem[dmem_addr] <= dmem_wdata;
        else if (sta_we) dmem[m] <= acc;
    end

endmodule

// File: doc/acc_cpu_p.md
ACC_CPU_P -- requirements
Module: acc_cpu_p

Interface
REQ-001 Parameter DATA_W, default 8: accumulator and data-memory word width, minimum 4.
REQ-002 Parameter ADDR_W, default 4: imem/dmem address width; each memory holds 2**ADDR_W words; instruction width IW = 4+ADDR_W.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  single-cycle run request.
REQ-006 imem_we / imem_addr / imem_wdata  in  1 / ADDR_W / IW  instruction-memory load port.
REQ-007 dmem_we / dmem_addr / dmem_wdata  in  1 / ADDR_W / DATA_W  data-memory load port.
REQ-008 pc  out  ADDR_W  program counter.
REQ-009 acc  out  DATA_W  accumulator.
REQ-010 zf, cf  out  1 each  zero and carry/borrow flags.
REQ-011 busy  out  1  high in FETCH or EXEC; halt  out  1  high in HALTED.

Function
REQ-012 FSM states IDLE, FETCH, EXEC, HALTED; IDLE/HALTED + start -> FETCH; FETCH -> EXEC always; EXEC -> HALTED on HLT, else FETCH.
REQ-013 Accepted start clears pc, acc, zf and cf to 0 on the same edge; start ignored while busy.
REQ-014 FETCH registers imem[pc] into ir; EXEC decodes ir; each instruction takes exactly 2 cycles.
REQ-015 Instruction format: ir[3:0] opcode, ir[IW-1:4] operand M (address or immediate).
REQ-016 Opcodes: 0 NOP; 1 LDA acc=dmem[M]; 2 STA dmem[M]=acc; 3 ADD acc+=dmem[M]; 4 SUB acc-=dmem[M]; 5 LDI acc=zero-extended M; 6 JMP pc=M; 7 JZ pc=M if zf; 8 JC pc=M if cf; 9 AND; A OR; F HLT; B-E execute as NOP.
REQ-017 Arithmetic modulo 2**DATA_W; ADD sets cf = carry out; SUB sets cf = 1 iff acc < dmem[M] (unsigned borrow).
REQ-018 zf updated to (new acc == 0) by LDA, ADD, SUB, LDI, AND, OR; cf updated only by ADD and SUB; other opcodes preserve both flags.
REQ-019 Non-jumping instructions and untaken JZ/JC set pc = pc+1, wrapping 2**ADDR_W-1 -> 0.
REQ-020 HLT leaves pc at the HLT address; acc, flags, pc hold in HALTED.
REQ-021 STA writes dmem at the EXEC edge; a following LDA of the same address returns the new value.
REQ-022 Load-port writes are accepted only when busy=0; ignored while busy.
REQ-023 Load-port write and start in the same idle cycle: both accepted; the first FETCH observes the written word.
REQ-024 Simultaneous imem_we and dmem_we are independent and both accepted.

Reset
REQ-025 rst forces state IDLE, pc=0, acc=0, zf=0, cf=0, busy=0, halt=0, ir=0, immediately and independent of clk.
REQ-026 Reset mid-program abandons the current instruction, with no partial STA write on the reset edge; memory contents are not cleared.
REQ-027 After rst deasserts the block stays IDLE until start.

Verification
REQ-028 Defaults, imem = {LDI 5, ADD @2, STA @3, LDA @3, HLT}, dmem[2]=7, start -> acc=12, halt=1, pc=4 after 10 cycles from start.
REQ-029 Defaults, acc=0xFF via LDA, ADD of 0x01 -> acc=0x00, zf=1, cf=1; next JC 9 -> pc=9.
REQ-030 LDI 3 then SUB of 5 -> acc=0xFE, cf=1, zf=0; JZ not taken, pc advances by 1.
REQ-031 JMP 15 then NOP at address 15 -> pc wraps to 0.
REQ-032 Assert rst during EXEC of STA -> target dmem word unchanged, outputs zero; start after reset reruns the program from pc=0.
REQ-033 DATA_W=16, ADDR_W=6: LDI 63 then ADD of 0xFFC1 -> acc=0x0000, cf=1, zf=1; imem_we while busy has no effect.
